// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its prefetch FIFO.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_INC  = 32'd4;
    localparam int          ENTRY_W = 64;

    // Packed with pc in the upper half so the raw 64-bit word reads as {pc, inst}.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO: flush beats push/pop, pointers wrap modulo DEPTH (power of two).
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  logic [WIDTH-1:0]               wdata,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [WIDTH-1:0]               head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry is only observable after a push has written it.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_prefetch_ctrl.sv
// Fetch PC sequencer feeding decode through a prefetch FIFO.
// Optional macro FETCH_PERF_EN enables the perf_fetched / perf_flushed counters.
module fetch_prefetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          ADDR_WID = 30,
    parameter int          FIFO_DEP = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic [ADDR_WID-1:0]               imem_addr,
    input  logic [31:0]                       imem_rdata,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [31:0]                       out_inst,
    output logic [31:0]                       out_pc,
    input  logic                              redirect_valid,
    input  logic [31:0]                       redirect_pc,
    input  logic                              halt_req,
    output logic                              halted,
    output logic [$clog2(FIFO_DEP+1)-1:0]     fifo_count,
    output logic [31:0]                       perf_fetched,
    output logic [31:0]                       perf_flushed
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         push, pop, full;
    fetch_entry_t wr_entry, head_entry;

    assign full     = (fifo_count == FIFO_DEP);
    assign wr_entry = '{pc: pc_q, inst: imem_rdata};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pop     = out_valid & out_ready & ~redirect_valid;
        push    = (state_q == RUN) & ~halt_req & ~redirect_valid & (~full | pop);
        if (redirect_valid) begin
            // Redirect restarts fetch from the aligned target but leaves the FSM where it is.
            pc_d = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (push) pc_d = pc_q + PC_INC;
            case (state_q)
                BOOT, RUN, HALT: state_d = halt_req ? HALT : RUN;
                default:         state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEP),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .count (fifo_count),
        .head  (head_entry)
    );

    assign imem_addr = pc_q[ADDR_WID+1:2];
    assign out_valid = (fifo_count != '0);
    assign out_inst  = head_entry.inst;
    assign out_pc    = head_entry.pc;
    assign halted    = (state_q == HALT);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + {31'd0, push};
        perf_flushed_d = perf_flushed_q;
        if (redirect_valid) perf_flushed_d = perf_flushed_q + 32'(fifo_count);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`else
    assign perf_fetched = 32'd0;
    assign perf_flushed = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_prefetch_ctrl.sv
// Self-checking bench for fetch_prefetch_ctrl: directed vector table, corner sequences, random vs queue model.
module tb_fetch_prefetch_ctrl;

    localparam int          ADDR_WID = 30;
    localparam int          FIFO_DEP = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic                clk = 1'b0;
    logic                rst;
    logic [ADDR_WID-1:0] imem_addr;
    logic [31:0]         imem_rdata;
    logic                out_valid, out_ready;
    logic [31:0]         out_inst, out_pc;
    logic                redirect_valid;
    logic [31:0]         redirect_pc;
    logic                halt_req, halted;
    logic [2:0]          fifo_count;
    logic [31:0]         perf_fetched, perf_flushed;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 32'hA000_0000 + {2'b00, imem_addr};

    fetch_prefetch_ctrl #(
        .ADDR_WID (ADDR_WID),
        .FIFO_DEP (FIFO_DEP),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted),
        .fifo_count     (fifo_count),
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
    );

    // Reference model: a queue of {pc, inst} plus fetch PC and boot/pause flags.
    logic [63:0] mq[$];
    logic [31:0] m_pc = RESET_PC;
    bit          m_boot = 1'b1;
    bit          m_paused = 1'b0;
    logic [31:0] m_fetched = 0, m_flushed = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return 32'hA000_0000 + (pc >> 2);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit pop_m, push_m;
        if (rst) begin
            mq.delete();
            m_pc = RESET_PC; m_boot = 1; m_paused = 0; m_fetched = 0; m_flushed = 0;
        end else if (redirect_valid) begin
            m_flushed += 32'(mq.size());
            mq.delete();
            m_pc = redirect_pc & ~32'h3;
        end else begin
            pop_m  = (mq.size() > 0) && out_ready;
            push_m = !m_boot && !m_paused && !halt_req && ((mq.size() < FIFO_DEP) || pop_m);
            if (pop_m) void'(mq.pop_front());
            if (push_m) begin
                mq.push_back({m_pc, mem_word(m_pc)});
                m_pc += 4;
                m_fetched++;
            end
            m_boot = 0;
            m_paused = halt_req;
        end
    endtask

    task automatic check_model();
        check("m_valid", 64'(out_valid), 64'(mq.size() != 0));
        check("m_count", 64'(fifo_count), 64'(mq.size()));
        check("m_halted", 64'(halted), 64'(m_paused));
        check("m_addr", 64'(imem_addr), 64'(m_pc[31:2]));
        if (mq.size() != 0) check("m_head", {out_pc, out_inst}, mq[0]);
`ifdef FETCH_PERF_EN
        check("m_perf_fetched", 64'(perf_fetched), 64'(m_fetched));
        check("m_perf_flushed", 64'(perf_flushed), 64'(m_flushed));
`else
        check("perf_tied", {perf_fetched, perf_flushed}, 64'd0);
`endif
    endtask

    // Apply inputs for one cycle, advance the model at the edge, sample at the falling edge.
    task automatic step(input logic r, input logic rdy, input logic rv,
                        input logic [31:0] rpc, input logic h);
        rst = r; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc; halt_req = h;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic        rst, ready, redir;
        logic [31:0] rpc;
        logic        halt;
        logic        e_valid;
        logic [31:0] e_pc;
        int          e_count;
        logic        e_halted;
        logic [29:0] e_addr;
    } vec_t;

    vec_t vecs[16];

    initial begin
        rst = 1; out_ready = 0; redirect_valid = 0; redirect_pc = 0; halt_req = 0;

        //          rst rdy rv  rpc           h  v  pc            cnt hl addr
        vecs[0]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 30'h40};
        vecs[1]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 30'h40};
        vecs[2]  = '{0, 0, 0, 32'h0,        0, 1, 32'h100,      1, 0, 30'h41};
        vecs[3]  = '{0, 0, 0, 32'h0,        0, 1, 32'h100,      2, 0, 30'h42};
        vecs[4]  = '{0, 0, 0, 32'h0,        0, 1, 32'h100,      3, 0, 30'h43};
        vecs[5]  = '{0, 0, 1, 32'h203,      0, 0, 32'h0,        0, 0, 30'h80};
        vecs[6]  = '{0, 1, 0, 32'h0,        0, 1, 32'h200,      1, 0, 30'h81};
        vecs[7]  = '{0, 1, 0, 32'h0,        0, 1, 32'h204,      1, 0, 30'h82};
        vecs[8]  = '{0, 1, 1, 32'h300,      0, 0, 32'h0,        0, 0, 30'hC0};
        vecs[9]  = '{0, 1, 0, 32'h0,        0, 1, 32'h300,      1, 0, 30'hC1};
        vecs[10] = '{0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 1, 30'hC1};
        vecs[11] = '{0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 1, 30'hC1};
        vecs[12] = '{0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 30'hC1};
        vecs[13] = '{0, 1, 0, 32'h0,        0, 1, 32'h304,      1, 0, 30'hC2};
        vecs[14] = '{0, 0, 0, 32'h0,        0, 1, 32'h304,      2, 0, 30'hC3};
        vecs[15] = '{1, 1, 1, 32'h500,      0, 0, 32'h0,        0, 0, 30'h40};

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst, vecs[i].ready, vecs[i].redir, vecs[i].rpc, vecs[i].halt);
            check($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vecs[i].e_valid));
            check($sformatf("v%0d_count", i), 64'(fifo_count), 64'(vecs[i].e_count));
            check($sformatf("v%0d_halted", i), 64'(halted), 64'(vecs[i].e_halted));
            check($sformatf("v%0d_addr", i), 64'(imem_addr), 64'(vecs[i].e_addr));
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d_pc", i), 64'(out_pc), 64'(vecs[i].e_pc));
                check($sformatf("v%0d_inst", i), 64'(out_inst), 64'(mem_word(vecs[i].e_pc)));
            end
`ifdef FETCH_PERF_EN
            if (i == 5) check("v5_perf_flushed", 64'(perf_flushed), 64'd3);
`endif
        end

        // Back-pressure: fill to depth, then full-rate push+pop with no gaps or duplicates.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 0, 0, 0, 0);
        check("bp_count", 64'(fifo_count), 64'd4);
        check("bp_addr", 64'(imem_addr), 64'h44);
        check("bp_head", 64'(out_pc), 64'h100);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0, 0);
            check($sformatf("bp_stream%0d_pc", i), 64'(out_pc), 64'(32'h104 + 32'(4 * i)));
            check($sformatf("bp_stream%0d_count", i), 64'(fifo_count), 64'd4);
        end

        // PC wrap across the top of the address space.
        step(0, 1, 1, 32'hFFFF_FFF9, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        check("wrap_addr", 64'(imem_addr), 64'h2);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic        r, rdy, rv, h;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            h   = ($urandom_range(0, 9) == 0) ? ~halt_req : halt_req;
            step(r, rdy, rv, rpc, h);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
